// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multicycle IF/ID/EX/MEM/WB control FSM.
// Sequences one instruction at a time. It issues the stage strobes and handles
// wait-stated instruction and data memories through req/ready handshakes.
// The core stops on halt_req (at a boundary), SYSTEM, illegal opcodes and
// memory timeouts.
//
// state   | meaning
// IDLE    | out of reset, waiting for run
// FETCH   | imem_req high, waiting for imem_ready
// DECODE  | one cycle, classify opcode
// EXECUTE | one cycle, branch retires here
// MEM     | dmem_req high, waiting for dmem_ready, store retires here
// WB      | reg_we + pc_we, retire
// HALT    | stopped, strobes low, run resumes
module cpu_sequencer #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             halt_req,
    input  logic [6:0]       opcode,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_we,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             pc_we,
    output logic             reg_we,
    output logic             busy,
    output logic             illegal,
    output logic             bus_err,
    output logic [WIDTH-1:0] instret
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [1:0] {K_ALU, K_LOAD, K_STORE, K_BRANCH} kind_t;

    // Wait budget is a down-counter loaded on entry to FETCH/MEM; a missing
    // ready while it sits at zero is the last permitted wait, hence timeout.
    localparam logic [7:0] WAIT_LOAD = 8'(TIMEOUT - 1);

    state_t     state;
    kind_t      kind;
    logic [7:0] wait_cnt;
    logic       pc_we_q;
    logic       op_legal;
    logic       op_system;
    kind_t      op_kind;
    logic       store_done;
    logic       retire;

    // Opcode classification used in DECODE
    always_comb begin
        op_legal  = 1'b1;
        op_system = 1'b0;
        op_kind   = K_ALU;
        case (opcode)
            7'b0110011, 7'b0010011, 7'b0110111: op_kind = K_ALU;
            7'b0000011: op_kind = K_LOAD;
            7'b0100011: op_kind = K_STORE;
            7'b1100011: op_kind = K_BRANCH;
            7'b1110011: begin
                op_legal  = 1'b0;
                op_system = 1'b1;
            end
            default: op_legal = 1'b0;
        endcase
    end

    // The only ready-dependent strobes: IR load and store completion
    assign store_done = (state == S_MEM) && (kind == K_STORE) && dmem_ready;
    assign ir_we      = (state == S_FETCH) && imem_ready;
    assign pc_we      = pc_we_q | store_done;
    assign retire     = pc_we;

    // Sequencer FSM; strobes are registered alongside the state they belong to
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            kind     <= K_ALU;
            wait_cnt <= '0;
            imem_req <= 1'b0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            reg_we   <= 1'b0;
            pc_we_q  <= 1'b0;
            busy     <= 1'b0;
            illegal  <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            imem_req <= 1'b0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            reg_we   <= 1'b0;
            pc_we_q  <= 1'b0;
            case (state)
                S_IDLE, S_HALT: begin
                    if (run) begin
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                        busy     <= 1'b1;
                        wait_cnt <= WAIT_LOAD;
                        illegal  <= 1'b0;
                        bus_err  <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        state <= S_DECODE;
                    end else if (wait_cnt == '0) begin
                        state   <= S_HALT;
                        busy    <= 1'b0;
                        bus_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                        imem_req <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if (op_legal) begin
                        state   <= S_EXECUTE;
                        kind    <= op_kind;
                        pc_we_q <= (op_kind == K_BRANCH);
                    end else begin
                        state   <= S_HALT;
                        busy    <= 1'b0;
                        illegal <= !op_system;
                    end
                end
                S_EXECUTE: begin
                    case (kind)
                        K_BRANCH: begin
                            if (halt_req) begin
                                state <= S_HALT;
                                busy  <= 1'b0;
                            end else begin
                                state    <= S_FETCH;
                                imem_req <= 1'b1;
                                wait_cnt <= WAIT_LOAD;
                            end
                        end
                        K_LOAD, K_STORE: begin
                            state    <= S_MEM;
                            dmem_req <= 1'b1;
                            dmem_we  <= (kind == K_STORE);
                            wait_cnt <= WAIT_LOAD;
                        end
                        default: begin
                            state   <= S_WB;
                            reg_we  <= 1'b1;
                            pc_we_q <= 1'b1;
                        end
                    endcase
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        if (kind == K_STORE) begin
                            if (halt_req) begin
                                state <= S_HALT;
                                busy  <= 1'b0;
                            end else begin
                                state    <= S_FETCH;
                                imem_req <= 1'b1;
                                wait_cnt <= WAIT_LOAD;
                            end
                        end else begin
                            state   <= S_WB;
                            reg_we  <= 1'b1;
                            pc_we_q <= 1'b1;
                        end
                    end else if (wait_cnt == '0) begin
                        state   <= S_HALT;
                        busy    <= 1'b0;
                        bus_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                        dmem_req <= 1'b1;
                        dmem_we  <= (kind == K_STORE);
                    end
                end
                S_WB: begin
                    if (halt_req) begin
                        state <= S_HALT;
                        busy  <= 1'b0;
                    end else begin
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                        wait_cnt <= WAIT_LOAD;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret <= '0;
        end else if (retire) begin
            instret <= instret + WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Testbench for cpu_sequencer: directed instruction sequence with a retire
// scoreboard (expected reg_we/instret pushed at issue, popped on pc_we).
module tb_cpu_sequencer;
    localparam int TO = 4;
    localparam int W  = 8;

    localparam logic [6:0] OP_ALU   = 7'b0110011;
    localparam logic [6:0] OP_ALUI  = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_SYS   = 7'b1110011;
    localparam logic [6:0] OP_BAD   = 7'b0000000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         run;
    logic         halt_req;
    logic [6:0]   opcode;
    logic         imem_ready;
    logic         dmem_ready;
    logic         imem_req;
    logic         ir_we;
    logic         dmem_req;
    logic         dmem_we;
    logic         pc_we;
    logic         reg_we;
    logic         busy;
    logic         illegal;
    logic         bus_err;
    logic [W-1:0] instret;

    typedef struct {
        logic [W-1:0] instret_after;
        logic         reg_we;
    } retire_t;

    retire_t      sbq[$];
    int           n_pass = 0;
    int           n_total = 0;
    logic [W-1:0] model_instret = '0;
    logic         pend_v = 1'b0;
    logic [W-1:0] pend_val = '0;

    cpu_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .halt_req   (halt_req),
        .opcode     (opcode),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .imem_req   (imem_req),
        .ir_we      (ir_we),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .pc_we      (pc_we),
        .reg_we     (reg_we),
        .busy       (busy),
        .illegal    (illegal),
        .bus_err    (bus_err),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One clock: drive readies mid-cycle, sample later in the same cycle,
    // then settle the scoreboard against any retire seen.
    task automatic cyc(input logic imr, input logic dmr);
        retire_t r;
        @(posedge clk);
        #2;
        imem_ready = imr;
        dmem_ready = dmr;
        #2;
        if (pend_v) begin
            chkn("instret_after_retire", 32'(instret), 32'(pend_val));
            pend_v = 1'b0;
        end
        if (pc_we === 1'b1) begin
            chk1("sb_has_entry", sbq.size() != 0, 1'b1);
            if (sbq.size() != 0) begin
                r = sbq.pop_front();
                chk1("retire_reg_we", reg_we, r.reg_we);
                pend_v   = 1'b1;
                pend_val = r.instret_after;
            end
        end
    endtask

    // Issue one instruction starting from the cycle before FETCH.
    // iw/dw: wait cycles before ready (>= TO means never ready).
    task automatic do_instr(input string name, input logic [6:0] op,
                            input int iw, input int dw, input logic hreq);
        logic legal, sys, is_ld, is_st, is_br, mem_op, to_i, to_d;
        legal = 1'b1; sys = 1'b0; is_ld = 1'b0; is_st = 1'b0; is_br = 1'b0;
        case (op)
            OP_ALU, OP_ALUI, OP_LUI: legal = 1'b1;
            OP_LOAD:  is_ld = 1'b1;
            OP_STORE: is_st = 1'b1;
            OP_BR:    is_br = 1'b1;
            OP_SYS: begin legal = 1'b0; sys = 1'b1; end
            default:  legal = 1'b0;
        endcase
        mem_op   = is_ld | is_st;
        to_i     = (iw >= TO);
        to_d     = mem_op && (dw >= TO);
        opcode   = op;
        halt_req = 1'b0;
        if (legal && !to_i && !to_d) begin
            model_instret = model_instret + 1'b1;
            sbq.push_back('{model_instret, !(is_br || is_st)});
        end
        for (int i = 0; i < TO; i++) begin
            cyc(i == iw, 1'b0);
            run = 1'b0;
            chk1({name, ":fetch_imem_req"}, imem_req, 1'b1);
            chk1({name, ":fetch_ir_we"}, ir_we, i == iw);
            chk1({name, ":fetch_busy"}, busy, 1'b1);
            if (i == 0) begin
                chk1({name, ":fetch_illegal_clr"}, illegal, 1'b0);
                chk1({name, ":fetch_bus_err_clr"}, bus_err, 1'b0);
            end
            if (i == iw) break;
        end
        if (to_i) begin
            cyc(1'b0, 1'b0);
            chk1({name, ":ito_imem_req"}, imem_req, 1'b0);
            chk1({name, ":ito_busy"}, busy, 1'b0);
            chk1({name, ":ito_bus_err"}, bus_err, 1'b1);
            chkn({name, ":ito_instret"}, 32'(instret), 32'(model_instret));
            return;
        end
        cyc(1'b0, 1'b0);
        halt_req = hreq;
        chk1({name, ":dec_busy"}, busy, 1'b1);
        chk1({name, ":dec_imem_req"}, imem_req, 1'b0);
        chk1({name, ":dec_pc_we"}, pc_we, 1'b0);
        if (!legal) begin
            cyc(1'b0, 1'b0);
            chk1({name, ":stop_busy"}, busy, 1'b0);
            chk1({name, ":stop_illegal"}, illegal, !sys);
            chk1({name, ":stop_pc_we"}, pc_we, 1'b0);
            chkn({name, ":stop_instret"}, 32'(instret), 32'(model_instret));
            return;
        end
        cyc(1'b0, 1'b0);
        chk1({name, ":ex_pc_we"}, pc_we, is_br);
        chk1({name, ":ex_reg_we"}, reg_we, 1'b0);
        chk1({name, ":ex_dmem_req"}, dmem_req, 1'b0);
        if (is_br) return;
        if (mem_op) begin
            for (int i = 0; i < TO; i++) begin
                cyc(1'b0, i == dw);
                chk1({name, ":mem_dmem_req"}, dmem_req, 1'b1);
                chk1({name, ":mem_dmem_we"}, dmem_we, is_st);
                chk1({name, ":mem_reg_we"}, reg_we, 1'b0);
                chk1({name, ":mem_pc_we"}, pc_we, is_st && (i == dw));
                if (i == dw) break;
            end
            if (to_d) begin
                cyc(1'b0, 1'b0);
                chk1({name, ":dto_dmem_req"}, dmem_req, 1'b0);
                chk1({name, ":dto_busy"}, busy, 1'b0);
                chk1({name, ":dto_bus_err"}, bus_err, 1'b1);
                chkn({name, ":dto_instret"}, 32'(instret), 32'(model_instret));
                return;
            end
            if (is_st) return;
        end
        cyc(1'b0, 1'b0);
        chk1({name, ":wb_reg_we"}, reg_we, 1'b1);
        chk1({name, ":wb_pc_we"}, pc_we, 1'b1);
        chk1({name, ":wb_dmem_req"}, dmem_req, 1'b0);
    endtask

    task automatic expect_halt(input string name);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b0);
            chk1({name, ":halt_busy"}, busy, 1'b0);
            chk1({name, ":halt_imem_req"}, imem_req, 1'b0);
            chk1({name, ":halt_pc_we"}, pc_we, 1'b0);
            chk1({name, ":halt_reg_we"}, reg_we, 1'b0);
        end
        halt_req = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; halt_req = 1'b0; opcode = OP_ALU;
        imem_ready = 1'b0; dmem_ready = 1'b0;
        #3;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_imem_req", imem_req, 1'b0);
        chk1("rst_pc_we", pc_we, 1'b0);
        chk1("rst_illegal", illegal, 1'b0);
        chkn("rst_instret", 32'(instret), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        cyc(1'b0, 1'b0);
        chk1("idle_busy", busy, 1'b0);
        chk1("idle_imem_req", imem_req, 1'b0);

        run = 1'b1;
        do_instr("alu", OP_ALU, 0, 0, 1'b0);
        do_instr("alui", OP_ALUI, 0, 0, 1'b0);
        do_instr("lui", OP_LUI, 1, 0, 1'b0);
        do_instr("load_w3", OP_LOAD, 0, 3, 1'b0);
        do_instr("store_w0", OP_STORE, 0, 0, 1'b0);
        do_instr("store_w2", OP_STORE, 2, 2, 1'b0);
        do_instr("branch", OP_BR, 3, 0, 1'b0);
        do_instr("load_w0", OP_LOAD, 0, 0, 1'b0);
        do_instr("system", OP_SYS, 0, 0, 1'b0);

        run = 1'b1;
        do_instr("illegal", OP_BAD, 0, 0, 1'b0);
        run = 1'b1;
        do_instr("after_ill", OP_ALU, 0, 0, 1'b0);
        do_instr("fetch_to", OP_ALU, TO, 0, 1'b0);
        run = 1'b1;
        do_instr("after_fto", OP_STORE, 0, 1, 1'b0);
        do_instr("data_to", OP_LOAD, 0, TO, 1'b0);
        run = 1'b1;
        do_instr("br_halt", OP_BR, 0, 0, 1'b1);
        expect_halt("br_halt");
        chkn("br_halt_instret", 32'(instret), 32'(model_instret));

        opcode = OP_LOAD;
        run = 1'b1;
        cyc(1'b1, 1'b0);
        run = 1'b0;
        chk1("abort_ir_we", ir_we, 1'b1);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        chk1("abort_mem_req", dmem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("abort_dmem_req", dmem_req, 1'b0);
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_reg_we", reg_we, 1'b0);
        chkn("abort_instret", 32'(instret), 32'd0);
        dmem_ready = 1'b1;
        @(posedge clk);
        #2;
        chk1("abort_edge_pc_we", pc_we, 1'b0);
        chk1("abort_edge_reg_we", reg_we, 1'b0);
        chkn("abort_edge_instret", 32'(instret), 32'd0);
        dmem_ready = 1'b0;
        rst_n = 1'b1;
        model_instret = '0;

        run = 1'b1;
        for (int k = 0; k < 256; k++) begin
            do_instr("wrap", OP_BR, 0, 0, k == 255);
        end
        expect_halt("wrap");
        chkn("instret_wrap", 32'(instret), 32'd0);
        chkn("sb_drained", 32'(sbq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
